// File: rtl/axi_rd_arbiter.sv
// Two-master AXI3 read-channel arbiter with a single transaction in flight.
// Optional burst-length checker is built when AXI_RD_ARB_CHECK_EN is defined.
module axi_rd_arbiter #(
  parameter int PRIO_M0 = 0
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [1:0]  m_arvalid,
  output logic [1:0]  m_arready,
  input  logic [63:0] m_araddr,
  input  logic [7:0]  m_arlen,
  input  logic [7:0]  m_arid,
  output logic [1:0]  m_rvalid,
  input  logic [1:0]  m_rready,
  output logic [63:0] m_rdata,
  output logic [3:0]  m_rresp,
  output logic [1:0]  m_rlast,
  output logic        s_arvalid,
  input  logic        s_arready,
  output logic [31:0] s_araddr,
  output logic [3:0]  s_arlen,
  output logic [3:0]  s_arid,
  input  logic        s_rvalid,
  output logic        s_rready,
  input  logic [31:0] s_rdata,
  input  logic [1:0]  s_rresp,
  input  logic        s_rlast,
  output logic        err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0] state_reg, state_next;
  logic       g_reg, g_next;
  logic       lw_reg, lw_next;
  logic       pick;
  logic       in_addr, in_data;
  logic       ar_hs, r_hs;

  // Round-robin favours the master that did not win last time.
  always_comb begin
    if (PRIO_M0 != 0)      pick = ~m_arvalid[0];
    else if (&m_arvalid)   pick = ~lw_reg;
    else                   pick = m_arvalid[1];
  end

  assign in_addr = (state_reg == ADDR);
  assign in_data = (state_reg == DATA);

  assign s_arvalid = in_addr & m_arvalid[g_reg];
  assign s_araddr  = in_addr ? (g_reg ? m_araddr[63:32] : m_araddr[31:0]) : '0;
  assign s_arlen   = in_addr ? (g_reg ? m_arlen[7:4]    : m_arlen[3:0])   : '0;
  assign s_arid    = in_addr ? (g_reg ? m_arid[7:4]     : m_arid[3:0])    : '0;
  assign s_rready  = in_data & m_rready[g_reg];

  assign ar_hs = s_arvalid & s_arready;
  assign r_hs  = s_rvalid & s_rready;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_route
      logic own;
      assign own                  = (g_reg == 1'(gi));
      assign m_arready[gi]        = in_addr & own & s_arready;
      assign m_rvalid[gi]         = in_data & own & s_rvalid;
      assign m_rdata[32*gi +: 32] = (in_data & own) ? s_rdata : '0;
      assign m_rresp[2*gi +: 2]   = (in_data & own) ? s_rresp : '0;
      assign m_rlast[gi]          = in_data & own & s_rlast;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    g_next     = g_reg;
    lw_next    = lw_reg;
    case (state_reg)
      IDLE: if (|m_arvalid) begin
        state_next = ADDR;
        g_next     = pick;
      end
      ADDR: if (ar_hs) state_next = DATA;
      DATA: if (r_hs && s_rlast) begin
        state_next = IDLE;
        lw_next    = g_reg;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_reg <= IDLE;
      g_reg     <= 1'b0;
      lw_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      g_reg     <= g_next;
      lw_reg    <= lw_next;
    end
  end

`ifdef AXI_RD_ARB_CHECK_EN
  logic [3:0] len_reg;
  logic [4:0] beat_reg;
  logic [4:0] beat_inc;
  logic       at_end;
  logic       err_reg;

  // Saturating count so a runaway burst cannot wrap back onto the target.
  assign beat_inc = (&beat_reg) ? beat_reg : beat_reg + 5'd1;
  assign at_end   = (beat_inc == ({1'b0, len_reg} + 5'd1));

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      len_reg  <= '0;
      beat_reg <= '0;
      err_reg  <= 1'b0;
    end else if (ar_hs) begin
      len_reg  <= s_arlen;
      beat_reg <= '0;
    end else if (r_hs) begin
      beat_reg <= beat_inc;
      if (s_rlast != at_end) err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench: round-robin and fixed-priority instances driven in parallel,
// compared against a transaction-level reference model plus directed vector tables.
module tb_axi_rd_arbiter;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic        areset;
  logic [1:0]  m_arvalid, m_rready;
  logic [63:0] m_araddr;
  logic [7:0]  m_arlen, m_arid;
  logic        s_arready, s_rvalid, s_rlast;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;

  logic [1:0]  o_m_arready [2];
  logic [1:0]  o_m_rvalid  [2];
  logic [63:0] o_m_rdata   [2];
  logic [3:0]  o_m_rresp   [2];
  logic [1:0]  o_m_rlast   [2];
  logic        o_s_arvalid [2];
  logic [31:0] o_s_araddr  [2];
  logic [3:0]  o_s_arlen   [2];
  logic [3:0]  o_s_arid    [2];
  logic        o_s_rready  [2];
  logic        o_err       [2];

  axi_rd_arbiter #(.PRIO_M0(0)) u_rr (
    .aclk(aclk), .areset(areset),
    .m_arvalid(m_arvalid), .m_arready(o_m_arready[0]), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arid(m_arid), .m_rvalid(o_m_rvalid[0]), .m_rready(m_rready),
    .m_rdata(o_m_rdata[0]), .m_rresp(o_m_rresp[0]), .m_rlast(o_m_rlast[0]),
    .s_arvalid(o_s_arvalid[0]), .s_arready(s_arready), .s_araddr(o_s_araddr[0]),
    .s_arlen(o_s_arlen[0]), .s_arid(o_s_arid[0]), .s_rvalid(s_rvalid),
    .s_rready(o_s_rready[0]), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .err(o_err[0])
  );

  axi_rd_arbiter #(.PRIO_M0(1)) u_fp (
    .aclk(aclk), .areset(areset),
    .m_arvalid(m_arvalid), .m_arready(o_m_arready[1]), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arid(m_arid), .m_rvalid(o_m_rvalid[1]), .m_rready(m_rready),
    .m_rdata(o_m_rdata[1]), .m_rresp(o_m_rresp[1]), .m_rlast(o_m_rlast[1]),
    .s_arvalid(o_s_arvalid[1]), .s_arready(s_arready), .s_araddr(o_s_araddr[1]),
    .s_arlen(o_s_arlen[1]), .s_arid(o_s_arid[1]), .s_rvalid(s_rvalid),
    .s_rready(o_s_rready[1]), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .err(o_err[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model, one entry per instance (0 = round-robin, 1 = fixed priority).
  int owner  [2];   // granted master, -1 when no transaction is open
  bit adone  [2];   // address accepted, now waiting for data
  int last   [2];   // master that completed the previous transaction
  bit merr   [2];
  int mlen   [2];
  int mbeats [2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      owner[k] = -1; adone[k] = 0; last[k] = 1;
      merr[k] = 0; mlen[k] = 0; mbeats[k] = 0;
    end
  endfunction

  task automatic model_expect(input int k, output logic [127:0] ar_exp, output logic [127:0] r_exp);
    logic [1:0] mar, mrv, mrl;
    logic [63:0] rd;
    logic [3:0] rr, sl, si;
    logic sarv, srr;
    logic [31:0] sad;
    int o;
    mar = '0; mrv = '0; mrl = '0; rd = '0; rr = '0; sl = '0; si = '0;
    sarv = 0; srr = 0; sad = '0;
    o = owner[k];
    if (!areset && o >= 0) begin
      if (!adone[k]) begin
        sarv   = m_arvalid[o];
        sad    = m_araddr[32*o +: 32];
        sl     = m_arlen[4*o +: 4];
        si     = m_arid[4*o +: 4];
        mar[o] = s_arready;
      end else begin
        mrv[o]          = s_rvalid;
        rd[32*o +: 32]  = s_rdata;
        rr[2*o +: 2]    = s_rresp;
        mrl[o]          = s_rlast;
        srr             = m_rready[o];
      end
    end
    ar_exp = 128'({mar, sarv, sad, sl, si});
    r_exp  = 128'({mrv, rd, rr, mrl, srr, merr[k]});
  endtask

  function automatic void model_update();
    int o, c;
    if (areset) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      o = owner[k];
      if (o < 0) begin
        if (m_arvalid != 2'b00) begin
          c = -1;
          if (k == 1) c = m_arvalid[0] ? 0 : 1;
          else for (int j = 1; j <= 2; j++) if (c < 0 && m_arvalid[(last[k] + j) % 2]) c = (last[k] + j) % 2;
          owner[k] = c; adone[k] = 0;
        end
      end else if (!adone[k]) begin
        if (m_arvalid[o] && s_arready) begin
          adone[k] = 1; mlen[k] = int'(m_arlen[4*o +: 4]); mbeats[k] = 0;
        end
      end else if (s_rvalid && m_rready[o]) begin
`ifdef AXI_RD_ARB_CHECK_EN
        if (mbeats[k] < 31) mbeats[k]++;
        if (s_rlast != (mbeats[k] == mlen[k] + 1)) merr[k] = 1;
`endif
        if (s_rlast) begin
          last[k] = o; owner[k] = -1; adone[k] = 0;
        end
      end
    end
  endfunction

  logic [1:0]  snap_mar [2];
  logic [1:0]  snap_mrv [2];
  logic        snap_srr [2];
  logic [63:0] snap_rdata [2];
  logic        snap_err [2];
  logic [71:0] snap_tbl;

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic step();
    logic [127:0] ea, er;
    if (areset) model_reset();
    @(negedge aclk);
    for (int k = 0; k < 2; k++) begin
      model_expect(k, ea, er);
      check($sformatf("ar_side[%0d]", k),
            128'({o_m_arready[k], o_s_arvalid[k], o_s_araddr[k], o_s_arlen[k], o_s_arid[k]}), ea);
      check($sformatf("r_side[%0d]", k),
            128'({o_m_rvalid[k], o_m_rdata[k], o_m_rresp[k], o_m_rlast[k], o_s_rready[k], o_err[k]}), er);
      snap_mar[k] = o_m_arready[k]; snap_mrv[k] = o_m_rvalid[k]; snap_srr[k] = o_s_rready[k];
      snap_rdata[k] = o_m_rdata[k]; snap_err[k] = o_err[k];
    end
    snap_tbl = {o_s_arvalid[0], o_s_araddr[0], o_m_arready[0], o_m_rvalid[0],
                o_m_rdata[0][31:0], o_m_rlast[0], o_s_rready[0]};
    @(posedge aclk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    m_arvalid = '0; m_rready = '0; m_araddr = '0; m_arlen = '0; m_arid = '0;
    s_arready = 0; s_rvalid = 0; s_rlast = 0; s_rdata = '0; s_rresp = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    areset = 1; step(); step();
    areset = 0;
  endtask

  // Master m issues one burst; the slave returns nb beats with rlast on the last one.
  task automatic burst(input int m, input logic [31:0] addr, input logic [3:0] len,
                       input int nb, input int stall, input bit toggle);
    logic [31:0] sent [$];
    logic [31:0] got  [$];
    int idx, cyc;
    bit ar_done;
    idx = 0; cyc = 0; ar_done = 0;
    for (int i = 0; i < nb; i++) sent.push_back($urandom);
    idle_inputs();
    m_araddr[32*m +: 32] = addr;
    m_arlen[4*m +: 4]    = len;
    m_arid[4*m +: 4]     = 4'(m + 2);
    while (idx < nb && cyc < 80) begin
      m_arvalid = ar_done ? 2'b00 : (2'b01 << m);
      s_arready = (cyc >= stall);
      s_rvalid  = 1;
      s_rdata   = sent[idx];
      s_rlast   = (idx == nb - 1);
      s_rresp   = 2'(idx);
      m_rready  = (!toggle || (cyc % 2 == 1)) ? 2'b11 : 2'b00;
      step();
      if (snap_mar[0][m]) ar_done = 1;
      if (snap_mrv[0][m] && m_rready[m]) got.push_back(snap_rdata[0][32*m +: 32]);
      if (snap_srr[0]) idx++;
      cyc++;
    end
    idle_inputs();
    step();
    check("burst_beats", 128'(got.size()), 128'(nb));
    for (int i = 0; i < got.size() && i < nb; i++)
      check($sformatf("burst_data[%0d]", i), 128'(got[i]), 128'(sent[i]));
  endtask

  typedef struct {
    logic [1:0]  arv;
    logic        sar;
    logic        srv;
    logic [31:0] sdata;
    logic        slast;
    logic [1:0]  mrr;
    logic        e_sarv;
    logic [31:0] e_saddr;
    logic [1:0]  e_mar;
    logic [1:0]  e_mrv;
    logic [31:0] e_rdata0;
    logic [1:0]  e_rlast;
    logic        e_srr;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int q0 [$];
    int q1 [$];
    int cyc;

    // Single m0 burst, arlen=3: grant, address, one stalled beat, four beats, stray beat.
    tbl[0] = '{2'b01, 1'b1, 1'b0, 32'h0,        1'b0, 2'b11, 1'b0, 32'h0,   2'b00, 2'b00, 32'h0,        2'b00, 1'b0};
    tbl[1] = '{2'b01, 1'b1, 1'b0, 32'h0,        1'b0, 2'b11, 1'b1, 32'h100, 2'b01, 2'b00, 32'h0,        2'b00, 1'b0};
    tbl[2] = '{2'b00, 1'b1, 1'b1, 32'hCAFE0000, 1'b0, 2'b10, 1'b0, 32'h0,   2'b00, 2'b01, 32'hCAFE0000, 2'b00, 1'b0};
    tbl[3] = '{2'b00, 1'b1, 1'b1, 32'hCAFE0000, 1'b0, 2'b01, 1'b0, 32'h0,   2'b00, 2'b01, 32'hCAFE0000, 2'b00, 1'b1};
    tbl[4] = '{2'b00, 1'b1, 1'b1, 32'hCAFE0001, 1'b0, 2'b11, 1'b0, 32'h0,   2'b00, 2'b01, 32'hCAFE0001, 2'b00, 1'b1};
    tbl[5] = '{2'b00, 1'b1, 1'b1, 32'hCAFE0002, 1'b0, 2'b11, 1'b0, 32'h0,   2'b00, 2'b01, 32'hCAFE0002, 2'b00, 1'b1};
    tbl[6] = '{2'b00, 1'b1, 1'b1, 32'hCAFE0003, 1'b1, 2'b11, 1'b0, 32'h0,   2'b00, 2'b01, 32'hCAFE0003, 2'b01, 1'b1};
    tbl[7] = '{2'b00, 1'b1, 1'b1, 32'hCAFE0004, 1'b0, 2'b11, 1'b0, 32'h0,   2'b00, 2'b00, 32'h0,        2'b00, 1'b0};

    idle_inputs();
    areset = 1;
    model_reset();
    @(posedge aclk);
    #1;
    do_reset();

    m_araddr = {32'hDEAD0000, 32'h00000100};
    m_arlen  = {4'h7, 4'h3};
    m_arid   = {4'h9, 4'h5};
    for (int i = 0; i < 8; i++) begin
      m_arvalid = tbl[i].arv;  s_arready = tbl[i].sar; s_rvalid = tbl[i].srv;
      s_rdata   = tbl[i].sdata; s_rlast  = tbl[i].slast; m_rready = tbl[i].mrr;
      step();
      check($sformatf("vec[%0d]", i), 128'(snap_tbl),
            128'({tbl[i].e_sarv, tbl[i].e_saddr, tbl[i].e_mar, tbl[i].e_mrv,
                  tbl[i].e_rdata0, tbl[i].e_rlast, tbl[i].e_srr}));
    end

    // Contention: both masters request continuously with single-beat bursts.
    do_reset();
    m_arvalid = 2'b11; m_araddr = {32'h2000, 32'h1000}; m_arlen = 8'h00;
    s_arready = 1; s_rvalid = 1; s_rlast = 1; m_rready = 2'b11;
    cyc = 0;
    while ((q0.size() < 4 || q1.size() < 4) && cyc < 40) begin
      s_rdata = $urandom;
      step();
      if (snap_mar[0] != 2'b00) q0.push_back(int'(snap_mar[0][1]));
      if (snap_mar[1] != 2'b00) q1.push_back(int'(snap_mar[1][1]));
      cyc++;
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr_grant[%0d]", i), 128'(i < q0.size() ? q0[i] : 99), 128'(i % 2));
      check($sformatf("fp_grant[%0d]", i), 128'(i < q1.size() ? q1[i] : 99), 128'(0));
    end

    // Backpressure: address stalled 5 cycles, master ready toggling each cycle.
    do_reset();
    burst(1, 32'h3000, 4'd3, 4, 5, 1'b1);

    // Reset in the middle of a 4-beat burst, then a fresh m1 request.
    do_reset();
    m_arvalid = 2'b01; m_araddr = 64'h400; m_arlen = 8'h03; s_arready = 1; m_rready = 2'b01;
    step(); step();
    m_arvalid = 2'b00; s_rvalid = 1; s_rdata = 32'h11111111;
    step();
    s_rdata = 32'h22222222;
    areset = 1;
    step();
    for (int k = 0; k < 2; k++)
      check($sformatf("mid_reset_zero[%0d]", k),
            128'({snap_mar[k], snap_mrv[k], snap_srr[k], snap_rdata[k], snap_err[k]}), 128'(0));
    areset = 0;
    idle_inputs();
    step();
    burst(1, 32'h5000, 4'd1, 2, 0, 1'b0);

    // Early rlast: arlen=3 but the slave ends on beat 2.
    do_reset();
    burst(0, 32'h6000, 4'd3, 2, 0, 1'b0);
`ifdef AXI_RD_ARB_CHECK_EN
    check("err_set", 128'(snap_err[0]), 128'(1));
`else
    check("err_tied", 128'(snap_err[0]), 128'(0));
`endif
    burst(1, 32'h7000, 4'd0, 1, 0, 1'b0);
`ifdef AXI_RD_ARB_CHECK_EN
    check("err_sticky", 128'(snap_err[0]), 128'(1));
`else
    check("err_tied2", 128'(snap_err[0]), 128'(0));
`endif

    // Randomized traffic with occasional asynchronous resets.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      m_arvalid = 2'($urandom_range(0, 3));
      m_araddr  = {$urandom, $urandom};
      m_arlen   = 8'($urandom);
      m_arid    = 8'($urandom);
      s_arready = 1'($urandom_range(0, 1));
      s_rvalid  = 1'($urandom_range(0, 1));
      s_rdata   = $urandom;
      s_rresp   = 2'($urandom);
      s_rlast   = ($urandom_range(0, 3) == 0);
      m_rready  = 2'($urandom_range(0, 3));
      areset    = ($urandom_range(0, 149) == 0);
      step();
    end
    areset = 0;
    idle_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
